// File: rtl/vga_frame_sync_if.sv
// Signal bundle between the game domain, the VGA timing source and the
// frame-stable shadow registers feeding the pixel generator.
interface vga_frame_sync_if #(
    parameter int unsigned N_OBS = 10
);
    logic                 vs_n;
    logic                 upd_toggle;
    logic [N_OBS*10-1:0]  obs_xl_in;
    logic [N_OBS*10-1:0]  obs_xr_in;
    logic [N_OBS*9-1:0]   obs_yu_in;
    logic [N_OBS*9-1:0]   obs_yd_in;
    logic [8:0]           player_y_in;
    logic [1:0]           gamemode_in;

    logic [N_OBS*10-1:0]  obs_xl_vga;
    logic [N_OBS*10-1:0]  obs_xr_vga;
    logic [N_OBS*9-1:0]   obs_yu_vga;
    logic [N_OBS*9-1:0]   obs_yd_vga;
    logic [8:0]           player_y_vga;
    logic [1:0]           gamemode_vga;
    logic                 frame_toggle;
    logic                 latch_pulse;
    logic [15:0]          frame_cnt;
    logic [7:0]           drop_cnt;
    logic [7:0]           overrun_cnt;

    modport master (
        output vs_n, upd_toggle, obs_xl_in, obs_xr_in, obs_yu_in, obs_yd_in,
               player_y_in, gamemode_in,
        input  obs_xl_vga, obs_xr_vga, obs_yu_vga, obs_yd_vga, player_y_vga,
               gamemode_vga, frame_toggle, latch_pulse, frame_cnt, drop_cnt,
               overrun_cnt
    );

    modport slave (
        input  vs_n, upd_toggle, obs_xl_in, obs_xr_in, obs_yu_in, obs_yd_in,
               player_y_in, gamemode_in,
        output obs_xl_vga, obs_xr_vga, obs_yu_vga, obs_yd_vga, player_y_vga,
               gamemode_vga, frame_toggle, latch_pulse, frame_cnt, drop_cnt,
               overrun_cnt
    );
endinterface

// File: rtl/vga_frame_sync.sv
// Hands game state across to the VGA side once per frame, at vertical sync.
// Define VGA_FRAME_SYNC_STATS_EN to build the frame/drop/overrun counters.
module vga_frame_sync #(
    parameter int unsigned N_OBS       = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n_debounced,
    vga_frame_sync_if.slave        bus
);

    typedef enum logic [1:0] {StIdle, StArmed, StLatch} state_e;

    localparam logic [N_OBS*10-1:0] XRst = {N_OBS{10'd700}};
    localparam logic [N_OBS*9-1:0]  YRst = {N_OBS{9'd500}};

    logic [SYNC_STAGES-1:0] vs_sync_q;
    logic [SYNC_STAGES-1:0] upd_sync_q;
    logic                   vs_prev_q;
    logic                   upd_prev_q;
    logic                   vs_s;
    logic                   upd_s;
    logic                   vsync_start;
    logic                   upd_event;

    state_e                 state_q;
    logic [N_OBS*10-1:0]    obs_xl_q;
    logic [N_OBS*10-1:0]    obs_xr_q;
    logic [N_OBS*9-1:0]     obs_yu_q;
    logic [N_OBS*9-1:0]     obs_yd_q;
    logic [8:0]             player_y_q;
    logic [1:0]             gamemode_q;
    logic                   frame_toggle_q;
    logic                   latch_pulse_q;

    // vs_n idles high, so its chain resets to 1 to avoid a false frame start.
    always_ff @(posedge clk or negedge rst_n_debounced) begin
        if (!rst_n_debounced) begin
            vs_sync_q  <= '1;
            upd_sync_q <= '0;
            vs_prev_q  <= 1'b1;
            upd_prev_q <= 1'b0;
        end else begin
            vs_sync_q  <= {vs_sync_q[SYNC_STAGES-2:0], bus.vs_n};
            upd_sync_q <= {upd_sync_q[SYNC_STAGES-2:0], bus.upd_toggle};
            vs_prev_q  <= vs_s;
            upd_prev_q <= upd_s;
        end
    end

    assign vs_s        = vs_sync_q[SYNC_STAGES-1];
    assign upd_s       = upd_sync_q[SYNC_STAGES-1];
    assign vsync_start = vs_prev_q & ~vs_s;
    assign upd_event   = upd_prev_q ^ upd_s;

    always_ff @(posedge clk or negedge rst_n_debounced) begin
        if (!rst_n_debounced) begin
            state_q        <= StIdle;
            obs_xl_q       <= XRst;
            obs_xr_q       <= XRst;
            obs_yu_q       <= YRst;
            obs_yd_q       <= YRst;
            player_y_q     <= 9'd240;
            gamemode_q     <= 2'd0;
            frame_toggle_q <= 1'b0;
            latch_pulse_q  <= 1'b0;
        end else begin
            latch_pulse_q <= 1'b0;
            if (vsync_start) begin
                frame_toggle_q <= ~frame_toggle_q;
            end
            case (state_q)
                StIdle: begin
                    if (vsync_start && upd_event) begin
                        state_q <= StLatch;
                    end else if (upd_event) begin
                        state_q <= StArmed;
                    end
                end
                StArmed: begin
                    if (vsync_start) begin
                        state_q <= StLatch;
                    end
                end
                StLatch: begin
                    // Game inputs are stable here: the last toggle is already synchronized.
                    obs_xl_q      <= bus.obs_xl_in;
                    obs_xr_q      <= bus.obs_xr_in;
                    obs_yu_q      <= bus.obs_yu_in;
                    obs_yd_q      <= bus.obs_yd_in;
                    player_y_q    <= bus.player_y_in;
                    gamemode_q    <= bus.gamemode_in;
                    latch_pulse_q <= 1'b1;
                    state_q       <= upd_event ? StArmed : StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.obs_xl_vga   = obs_xl_q;
    assign bus.obs_xr_vga   = obs_xr_q;
    assign bus.obs_yu_vga   = obs_yu_q;
    assign bus.obs_yd_vga   = obs_yd_q;
    assign bus.player_y_vga = player_y_q;
    assign bus.gamemode_vga = gamemode_q;
    assign bus.frame_toggle = frame_toggle_q;
    assign bus.latch_pulse  = latch_pulse_q;

`ifdef VGA_FRAME_SYNC_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [7:0]  drop_cnt_q;
    logic [7:0]  overrun_cnt_q;

    always_ff @(posedge clk or negedge rst_n_debounced) begin
        if (!rst_n_debounced) begin
            frame_cnt_q   <= '0;
            drop_cnt_q    <= '0;
            overrun_cnt_q <= '0;
        end else begin
            if (vsync_start) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (vsync_start && !upd_event && (state_q == StIdle) && (drop_cnt_q != 8'hff)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
            if (upd_event && (state_q == StArmed) && (overrun_cnt_q != 8'hff)) begin
                overrun_cnt_q <= overrun_cnt_q + 8'd1;
            end
        end
    end

    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.drop_cnt    = drop_cnt_q;
    assign bus.overrun_cnt = overrun_cnt_q;
`else
    assign bus.frame_cnt   = '0;
    assign bus.drop_cnt    = '0;
    assign bus.overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_frame_sync.sv
// Directed bench for vga_frame_sync: reset values, frame repeat, latch timing,
// overrun, simultaneous update/vsync and reset during the load cycle.
module tb_vga_frame_sync;
    localparam int unsigned N = 10;
`ifdef VGA_FRAME_SYNC_STATS_EN
    localparam int unsigned StatsOn = 1;
`else
    localparam int unsigned StatsOn = 0;
`endif

    logic clk = 1'b0;
    logic rst_n_debounced = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    vga_frame_sync_if #(.N_OBS(N)) bus ();

    vga_frame_sync #(.N_OBS(N), .SYNC_STAGES(2)) dut (
        .clk             (clk),
        .rst_n_debounced (rst_n_debounced),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic vs_pulse();
        bus.vs_n = 1'b0;
        tick(6);
        bus.vs_n = 1'b1;
        tick(6);
    endtask

    task automatic chk_stats(input string tag, input int f, input int d, input int o);
        chk({tag, "_frame"}, 128'(bus.frame_cnt), 128'(StatsOn * f));
        chk({tag, "_drop"}, 128'(bus.drop_cnt), 128'(StatsOn * d));
        chk({tag, "_overrun"}, 128'(bus.overrun_cnt), 128'(StatsOn * o));
    endtask

    initial begin
        logic [N*10-1:0] xrst;
        logic [N*9-1:0]  yrst;
        logic [N*10-1:0] x123;
        xrst = {N{10'd700}};
        yrst = {N{9'd500}};
        x123 = {N{10'd123}};

        bus.vs_n        = 1'b1;
        bus.upd_toggle  = 1'b0;
        bus.obs_xl_in   = {N{10'd5}};
        bus.obs_xr_in   = {N{10'd6}};
        bus.obs_yu_in   = {N{9'd7}};
        bus.obs_yd_in   = {N{9'd8}};
        bus.player_y_in = 9'd77;
        bus.gamemode_in = 2'd3;
        tick(3);

        chk("rst_xl", 128'(bus.obs_xl_vga), 128'(xrst));
        chk("rst_xr", 128'(bus.obs_xr_vga), 128'(xrst));
        chk("rst_yu", 128'(bus.obs_yu_vga), 128'(yrst));
        chk("rst_yd", 128'(bus.obs_yd_vga), 128'(yrst));
        chk("rst_player", 128'(bus.player_y_vga), 128'(240));
        chk("rst_mode", 128'(bus.gamemode_vga), 128'(0));
        chk("rst_ftog", 128'(bus.frame_toggle), 128'(0));
        chk("rst_lp", 128'(bus.latch_pulse), 128'(0));
        chk_stats("rst", 0, 0, 0);
        rst_n_debounced = 1'b1;
        tick(4);

        // Three frames with no new data: repeats only.
        vs_pulse();
        vs_pulse();
        vs_pulse();
        chk("rep_xl", 128'(bus.obs_xl_vga), 128'(xrst));
        chk("rep_yd", 128'(bus.obs_yd_vga), 128'(yrst));
        chk("rep_player", 128'(bus.player_y_vga), 128'(240));
        chk("rep_mode", 128'(bus.gamemode_vga), 128'(0));
        chk("rep_ftog", 128'(bus.frame_toggle), 128'(1));
        chk_stats("rep", 3, 3, 0);

        // Latch timing: vs_n sampled low at edge 1, load at edge 4.
        bus.player_y_in = 9'd100;
        bus.obs_xl_in   = x123;
        bus.gamemode_in = 2'd2;
        bus.upd_toggle  = 1'b1;
        tick(6);
        bus.vs_n = 1'b0;
        tick(3);
        chk("lat_early_player", 128'(bus.player_y_vga), 128'(240));
        chk("lat_early_lp", 128'(bus.latch_pulse), 128'(0));
        chk("lat_ftog", 128'(bus.frame_toggle), 128'(0));
        tick(1);
        chk("lat_player", 128'(bus.player_y_vga), 128'(100));
        chk("lat_xl", 128'(bus.obs_xl_vga), 128'(x123));
        chk("lat_mode", 128'(bus.gamemode_vga), 128'(2));
        chk("lat_lp", 128'(bus.latch_pulse), 128'(1));
        tick(1);
        chk("lat_lp_end", 128'(bus.latch_pulse), 128'(0));
        bus.vs_n = 1'b1;
        tick(6);

        // Input changes during active video stay hidden until the next frame.
        bus.player_y_in = 9'd200;
        tick(10);
        chk("hold_player", 128'(bus.player_y_vga), 128'(100));
        bus.upd_toggle = 1'b0;
        tick(6);
        chk("hold_armed_player", 128'(bus.player_y_vga), 128'(100));
        vs_pulse();
        chk("hold_next_player", 128'(bus.player_y_vga), 128'(200));
        chk_stats("hold", 5, 3, 0);

        // Two updates before one frame: second data set wins.
        bus.player_y_in = 9'd50;
        bus.upd_toggle  = 1'b1;
        tick(6);
        bus.player_y_in = 9'd60;
        bus.upd_toggle  = 1'b0;
        tick(6);
        vs_pulse();
        chk("ovr_player", 128'(bus.player_y_vga), 128'(60));
        chk_stats("ovr", 6, 3, 1);

        // Update and vsync in the same clock from IDLE.
        bus.player_y_in = 9'd33;
        bus.upd_toggle  = 1'b1;
        bus.vs_n        = 1'b0;
        tick(4);
        chk("sim_player", 128'(bus.player_y_vga), 128'(33));
        chk("sim_lp", 128'(bus.latch_pulse), 128'(1));
        tick(2);
        bus.vs_n = 1'b1;
        tick(6);
        chk_stats("sim", 7, 3, 1);
        bus.player_y_in = 9'd44;
        vs_pulse();
        chk("sim_idle_player", 128'(bus.player_y_vga), 128'(33));
        chk_stats("sim_idle", 8, 4, 1);

        // Reset landing in the LATCH cycle aborts the load.
        bus.player_y_in = 9'd99;
        bus.upd_toggle  = 1'b0;
        tick(6);
        bus.vs_n = 1'b0;
        tick(3);
        rst_n_debounced = 1'b0;
        bus.vs_n = 1'b1;
        tick(1);
        chk("rl_player", 128'(bus.player_y_vga), 128'(240));
        chk("rl_lp", 128'(bus.latch_pulse), 128'(0));
        chk("rl_ftog", 128'(bus.frame_toggle), 128'(0));
        chk_stats("rl", 0, 0, 0);
        rst_n_debounced = 1'b1;
        tick(4);
        vs_pulse();
        chk("rl_idle_player", 128'(bus.player_y_vga), 128'(240));
        chk_stats("rl_idle", 1, 1, 0);

        // A toggle level of 1 at reset release counts as one update.
        rst_n_debounced = 1'b0;
        bus.upd_toggle  = 1'b1;
        bus.player_y_in = 9'd11;
        tick(1);
        rst_n_debounced = 1'b1;
        tick(6);
        vs_pulse();
        chk("rel_player", 128'(bus.player_y_vga), 128'(11));
        chk_stats("rel", 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_frame_sync.md
VGA_FRAME_SYNC -- requirements
Module: vga_frame_sync

Interface
REQ-001 Parameter N_OBS, default 10: number of obstacle slots per array.
REQ-002 Parameter SYNC_STAGES, default 2, legal 2..3: synchronizer depth for vs_n and upd_toggle.
REQ-003 clk  input  1  Main 100 MHz clock; the block is clocked only by clk.
REQ-004 rst_n_debounced  input  1  Reset, asynchronous, active-low.
REQ-005 vs_n  input  1  VGA vertical sync (active-low), asynchronous to clk.
REQ-006 upd_toggle  input  1  Publish toggle from the 60 Hz game domain, asynchronous; each level change announces a new game state.
REQ-007 obs_xl_in, obs_xr_in  input  N_OBS*10 each  Obstacle left/right x values, 10 bits per slot; slot i occupies bits [10i+9:10i].
REQ-008 obs_yu_in, obs_yd_in  input  N_OBS*9 each  Obstacle up/down y values, 9 bits per slot.
REQ-009 player_y_in  input  9, gamemode_in  input  2  Game state published with upd_toggle.
REQ-010 obs_xl_vga, obs_xr_vga, obs_yu_vga, obs_yd_vga, player_y_vga, gamemode_vga  output  same widths as the matching inputs  Frame-stable shadow copy for the pixel generator.
REQ-011 frame_toggle  output  1  Inverts once per vertical-sync start; the game domain consumes it as its frame tick.
REQ-012 latch_pulse  output  1  One-clk pulse in the cycle after the shadow registers load.
REQ-013 frame_cnt  output  16; drop_cnt  output  8; overrun_cnt  output  8  Statistics (REQ-027).

Function
REQ-014 Each asynchronous input (vs_n, upd_toggle) SHALL pass through its own SYNC_STAGES-flop synchronizer before any use.
REQ-015 vsync_start SHALL be a one-clk event on the synchronized 1->0 transition of vs_n.
REQ-016 upd_event SHALL be a one-clk event on any synchronized transition of upd_toggle.
REQ-017 The FSM SHALL have exactly three states: IDLE (no new data), ARMED (new data pending), LATCH (one-cycle load).
REQ-018 IDLE: upd_event -> ARMED; vsync_start without upd_event -> stay in IDLE, no load.
REQ-019 ARMED: vsync_start -> LATCH; upd_event -> stay in ARMED.
REQ-020 Simultaneous upd_event and vsync_start in IDLE -> LATCH; the new data is taken.
REQ-021 LATCH: load all shadow outputs from the inputs on the single clk edge that leaves LATCH.
REQ-022 LATCH exit: -> ARMED if upd_event is present in that cycle, else -> IDLE.
REQ-023 latch_pulse SHALL be high for exactly the one cycle after the load.
REQ-024 Shadow outputs SHALL change only on the LATCH load, so they never change during active video.
REQ-025 Load timing: shadow outputs SHALL update on the clk edge SYNC_STAGES+2 after vs_n is first sampled low.
REQ-026 frame_toggle SHALL invert on every vsync_start, whatever the FSM state, one cycle after vsync_start.
REQ-027 Statistics:
- frame_cnt SHALL increment on each vsync_start and wrap modulo 2^16.
- drop_cnt SHALL increment on vsync_start in IDLE without upd_event (repeated frame); saturates at 255.
- overrun_cnt SHALL increment on upd_event in ARMED (an unshown update is overwritten); saturates at 255.
REQ-028 The game domain holds the data inputs stable from the upd_toggle change until the next change; the block SHALL NOT sample data outside LATCH.

Reset
REQ-029 Reset SHALL take effect asynchronously and force:
- FSM to IDLE; all synchronizer flops to 1 for vs_n and 0 for upd_toggle.
- each obs_xl_vga and obs_xr_vga slot to 700; each obs_yu_vga and obs_yd_vga slot to 500.
- player_y_vga to 240; gamemode_vga to 0.
- frame_toggle, latch_pulse, frame_cnt, drop_cnt and overrun_cnt to 0.
REQ-030 Reset asserted during LATCH SHALL abort the load; the shadow outputs hold their reset values.
REQ-031 After reset release, a upd_toggle level differing from 0 SHALL produce one upd_event.

Configuration
REQ-032 Macro VGA_FRAME_SYNC_STATS_EN:
- defined: frame_cnt, drop_cnt and overrun_cnt SHALL behave as REQ-027.
- undefined: the three outputs SHALL be constant 0 and no counter flops SHALL be built.
- all other behaviour SHALL be identical either way.

Verification
REQ-033 Reset, then 3 vs_n pulses with upd_toggle static -> shadows stay 700/500/240/0; drop_cnt=3; frame_cnt=3; frame_toggle=1.
REQ-034 Set player_y_in=100, toggle upd_toggle, then one vs_n fall -> player_y_vga=100 exactly SYNC_STAGES+2 clks after vs_n is sampled low; latch_pulse high 1 cycle.
REQ-035 Change the inputs during active video after a latch -> shadows unchanged until the next vs_n fall.
REQ-036 Two upd_toggle changes before one vs_n fall -> overrun_cnt=1; second data set latched.
REQ-037 upd_toggle and vs_n change in the same clk -> data latched; FSM returns to IDLE; drop_cnt unchanged.
REQ-038 Assert rst_n_debounced in the LATCH cycle -> shadows at reset values; FSM IDLE; counters 0; with the macro undefined, counters read 0 throughout.
